audio_stream_ctrl: RTL and testbench
====================================

# audio_stream_ctrl

Sample-stream scheduler between the PmodMIC3 capture front end and the PmodI2S playback back end. It buffers microphone samples in a small FIFO and sequences playback start with a prefill phase. On every I2S frame request it supplies a left-justified stereo word, and it recovers from underrun and overflow without stalling either side. It sits between `pmodmic3` (`data`/`data_wr`) and `pmodi2s` (`data_l`/`data_r`/`data_rd`), replacing the direct wire connection.

## Interface
- `DEPTH`, 16: FIFO depth in samples; power of two, at least 4.
- `PREFILL`, 8: fill level required before playback starts; 1 ≤ PREFILL ≤ DEPTH.
- `IN_W`, 12: input sample width.
- `OUT_W`, 24: output word width; must be greater than IN_W+1.
- `clk`  in  1  system clock (98.304 MHz); single clock domain.
- `rst`  in  1  asynchronous, active-low reset.
- `enable`  in  1  high runs the stream; low flushes the FIFO and forces IDLE.
- `mute`  in  1  high forces both outputs to zero; FIFO keeps running.
- `in_data`  in  IN_W  microphone sample, unsigned.
- `in_wr`  in  1  one-cycle strobe: `in_data` is valid.
- `out_rd`  in  1  one-cycle strobe from I2S: current output words are consumed.
- `out_l`, `out_r`  out  OUT_W  playback words, identical; format `{1'b0, sample, zeros}`.
- `state`  out  2  0 = IDLE, 1 = FILL, 2 = RUN.
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- `underrun`, `overflow`  out  1  sticky error flags.
- `clr_flags`  in  1  synchronous clear of both sticky flags.

## Operation
- Reset (rst low): state=IDLE, level=0, out_l=out_r=0, underrun=overflow=0, FIFO pointers=0.
- IDLE:
  - FIFO held empty; in_wr ignored; outputs 0.
  - Go to FILL when enable=1.
- FILL:
  - in_wr pushes; out_rd does not pop, and outputs hold their current value.
  - Go to RUN on the edge where level (after any push that cycle) ≥ PREFILL.
- RUN:
  - in_wr pushes.
  - out_rd pops the head and loads `{1'b0, head, (OUT_W-IN_W-1)'b0}` into both outputs.
  - out_rd with level=0: outputs hold the previous word, underrun←1, go to FILL.
- enable=0 in any state: next edge → IDLE, FIFO flushed, outputs 0. A pending push or pop in that cycle is discarded.
- Full FIFO with in_wr=1 and no pop that cycle: the incoming sample is dropped and overflow←1. Stored data is unchanged.
- in_wr and out_rd in the same cycle in RUN with level>0: both take effect and level is unchanged. Allowed even when full; no overflow is flagged.
- mute=1: out_l/out_r register 0 on each update, and pops still occur. When mute deasserts, outputs stay 0 until the next pop.
- clr_flags has priority over a same-cycle flag set; both flags read 0 on the next edge.
- Pointer arithmetic wraps modulo DEPTH; level is a separate counter (+1 push, −1 pop, 0 both).

## Timing
- Push latency: sample is counted in `level` one edge after in_wr.
- Pop latency: out_l/out_r update on the edge after the out_rd strobe. They are stable for the rest of the I2S frame, which is required because pmodi2s samples the words after data_rd.
- FILL→RUN transition is registered one edge after the threshold is reached. An out_rd on that same edge is treated as in FILL.
- `state`, `level` and the flags are all registered outputs with no combinational path from inputs.
- Throughput: one push and one pop per cycle maximum; nominal rate is 48 kHz on each side.

## Structure
- Shared package `audio_pkg`:
  - state encoding constants ST_IDLE/ST_FILL/ST_RUN.
  - the `fmt_left_justify` width rule (sign pad bit plus zero fill), reused by future audio blocks.
- Sub-module `sample_fifo`:
  - synchronous DEPTH×IN_W register FIFO with push, pop, flush, full, empty and level.
  - Data out is the registered head, valid while not empty.
- The top module holds the state machine, output registers, mute and flags.

## Test plan
- Reset, enable=1, 8 pushes of 0x001..0x008 → state FILL until the 8th push, then RUN. The first out_rd gives out_l=out_r=0x000800. Level steps 8→7.
- RUN with 3 samples, 4 out_rd, no pushes → third pop outputs 0x003 word. The fourth pop sets underrun=1, holds 0x003 word and state=FILL.
- FIFO full (16), in_wr of 0xFFF alone → overflow=1, level=16, and the next pops show the original order with 0xFFF absent. Same-cycle in_wr+out_rd at full → level stays 16, overflow unchanged.
- mute=1 during RUN, 2 pops → outputs 0 and level drops by 2. Release mute → outputs remain 0 until the next pop.
- enable→0 mid-RUN with level=5 → next edge: IDLE, level=0, outputs 0. Re-enable → prefill restarts from empty.
- rst asserted asynchronously between edges during RUN → all outputs 0 immediately. clr_flags with a same-cycle underrun event → flag reads 0.

Source files
------------

// File: rtl/audio_pkg.sv
// audio_pkg: shared stream state encoding and left-justified word format rule.
package audio_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_FILL = 2'd1, ST_RUN = 2'd2} state_e;
  // Zero fill below the sample in a {sign pad, sample, zeros} output word.
  function automatic int fmt_pad_w(input int in_w, input int out_w);
    return out_w - in_w - 1;
  endfunction
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: register FIFO with flush and occupancy count; head is read straight from storage.
module sample_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 12,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [LW-1:0] lvl_q, lvl_d;
  logic          push_ok, pop_ok;
  assign empty_o = lvl_q == '0;
  assign full_o  = lvl_q == LW'(DEPTH);
  assign pop_ok  = pop_i && !empty_o;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign push_ok = push_i && (!full_o || pop_ok);
  assign lvl_d   = lvl_q + LW'(push_ok) - LW'(pop_ok);
  assign dout_o  = mem_q[rd_q];
  assign level_o = lvl_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      wr_q  <= push_ok ? wr_q + 1'b1 : wr_q;
      rd_q  <= pop_ok ? rd_q + 1'b1 : rd_q;
      lvl_q <= lvl_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/audio_stream_ctrl.sv
// audio_stream_ctrl: buffers mic samples and feeds I2S frames with prefill,
// underrun/overflow recovery and mute.
module audio_stream_ctrl
  import audio_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int PREFILL = 8,
  parameter int IN_W    = 12,
  parameter int OUT_W   = 24,
  localparam int LW     = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic             mute_i,
  input  logic [IN_W-1:0]  in_data_i,
  input  logic             in_wr_i,
  input  logic             out_rd_i,
  input  logic             clr_flags_i,
  output logic [OUT_W-1:0] out_l_o,
  output logic [OUT_W-1:0] out_r_o,
  output logic [1:0]       state_o,
  output logic [LW-1:0]    level_o,
  output logic             underrun_o,
  output logic             overflow_o
);
  localparam int PAD = fmt_pad_w(IN_W, OUT_W);
  state_e           state_q, state_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             urun_q, urun_d, ovf_q, ovf_d;
  logic             active, push, pop, under_ev, over_ev, full, empty;
  logic [IN_W-1:0]  head;
  logic [LW-1:0]    level, fill_lvl;
  assign active   = enable_i && state_q != ST_IDLE;
  assign push     = active && in_wr_i;
  assign pop      = active && state_q == ST_RUN && out_rd_i && !empty;
  assign under_ev = active && state_q == ST_RUN && out_rd_i && empty;
  assign over_ev  = push && full && !pop;
  assign fill_lvl = level + LW'(push && !full);
  sample_fifo #(.DEPTH(DEPTH), .W(IN_W)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (!active),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (in_data_i),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end
  always_comb begin
    state_d = !enable_i ? ST_IDLE :
              state_q == ST_IDLE ? ST_FILL :
              state_q == ST_FILL ? (fill_lvl >= LW'(PREFILL) ? ST_RUN : ST_FILL) :
              under_ev ? ST_FILL : ST_RUN;
  end
  // Underrun and non-pop cycles keep the last word so the I2S frame stays stable.
  always_comb begin
    out_d  = (!active || mute_i) ? '0 : pop ? {1'b0, head, {PAD{1'b0}}} : out_q;
    urun_d = clr_flags_i ? 1'b0 : urun_q | under_ev;
    ovf_d  = clr_flags_i ? 1'b0 : ovf_q | over_ev;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q  <= '0;
      urun_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      urun_q <= urun_d;
      ovf_q  <= ovf_d;
    end
  end
  assign out_l_o    = out_q;
  assign out_r_o    = out_q;
  assign state_o    = state_q;
  assign level_o    = level;
  assign underrun_o = urun_q;
  assign overflow_o = ovf_q;
endmodule

// File: tb/tb_audio_stream_ctrl.sv
// tb_audio_stream_ctrl: directed stimulus with a word scoreboard checked on every out_rd.
module tb_audio_stream_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, mute = 1'b0;
  logic        in_wr = 1'b0, out_rd = 1'b0, clr = 1'b0;
  logic [11:0] in_data = '0;
  logic [23:0] out_l, out_r;
  logic [1:0]  state;
  logic [4:0]  level;
  logic        underrun, overflow;
  int          total = 0, bad = 0;
  logic [23:0] exp_q [$];

  audio_stream_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .mute_i(mute),
    .in_data_i(in_data), .in_wr_i(in_wr), .out_rd_i(out_rd), .clr_flags_i(clr),
    .out_l_o(out_l), .out_r_o(out_r), .state_o(state), .level_o(level),
    .underrun_o(underrun), .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] w(input logic [11:0] s);
    return {1'b0, s, 11'b0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [11:0] d);
    in_data = d;
    in_wr = 1'b1;
    tick();
    in_wr = 1'b0;
  endtask

  task automatic rd(input logic [23:0] e);
    exp_q.push_back(e);
    out_rd = 1'b1;
    tick();
    out_rd = 1'b0;
  endtask

  // Monitor: every out_rd sampled on an edge is checked at the following falling edge.
  initial begin
    logic got;
    logic [23:0] e;
    forever begin
      @(posedge clk);
      got = out_rd;
      @(negedge clk);
      if (got) begin
        if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("out_l", out_l, e);
          chk("out_r", out_r, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    chk("rst_state", state, 0);
    chk("rst_level", level, 0);
    chk("rst_out", out_l, 0);
    chk("rst_flags", {underrun, overflow}, 0);
    #6 rst_n = 1'b1;
    enable = 1'b1;
    tick();
    chk("fill_state", state, 1);
    for (int i = 1; i <= 7; i++) push(12'(i));
    chk("pre7_state", state, 1);
    chk("pre7_level", level, 7);
    push(12'h008);
    chk("run_state", state, 2);
    chk("run_level", level, 8);
    rd(w(12'h001));
    chk("pop1_level", level, 7);
    for (int i = 2; i <= 8; i++) rd(w(12'(i)));
    chk("drained_level", level, 0);
    chk("drained_state", state, 2);
    rd(w(12'h008));
    chk("underrun_flag", underrun, 1);
    chk("underrun_state", state, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_underrun", underrun, 0);
    for (int i = 1; i <= 16; i++) push(12'h100 + 12'(i));
    chk("full_level", level, 16);
    chk("full_ovf", overflow, 0);
    push(12'hFFF);
    chk("ovf_flag", overflow, 1);
    chk("ovf_level", level, 16);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_ovf", overflow, 0);
    in_data = 12'h0AA;
    in_wr = 1'b1;
    rd(w(12'h101));
    in_wr = 1'b0;
    chk("both_full_level", level, 16);
    chk("both_full_ovf", overflow, 0);
    for (int i = 2; i <= 4; i++) rd(w(12'h100 + 12'(i)));
    mute = 1'b1;
    rd('0);
    rd('0);
    chk("mute_level", level, 11);
    mute = 1'b0;
    tick();
    chk("unmute_hold", out_l, 0);
    rd(w(12'h107));
    for (int i = 8; i <= 12; i++) rd(w(12'h100 + 12'(i)));
    chk("pre_dis_level", level, 5);
    enable = 1'b0;
    in_wr = 1'b1;
    rd('0);
    in_wr = 1'b0;
    chk("dis_state", state, 0);
    chk("dis_level", level, 0);
    enable = 1'b1;
    tick();
    chk("reen_state", state, 1);
    chk("reen_level", level, 0);
    for (int i = 1; i <= 3; i++) push(12'h020 + 12'(i));
    chk("refill_level", level, 3);
    chk("refill_state", state, 1);
    for (int i = 4; i <= 8; i++) push(12'h020 + 12'(i));
    chk("rerun_state", state, 2);
    for (int i = 1; i <= 8; i++) rd(w(12'h020 + 12'(i)));
    clr = 1'b1;
    rd(w(12'h028));
    clr = 1'b0;
    chk("clr_prio_underrun", underrun, 0);
    chk("clr_prio_state", state, 1);
    for (int i = 1; i <= 8; i++) push(12'h030 + 12'(i));
    rd(w(12'h031));
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out", out_l, 0);
    chk("arst_state", state, 0);
    chk("arst_level", level, 0);
    rst_n = 1'b1;
    tick();
    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
